data_cache_ctrl: RTL and testbench
==================================

DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

Interface
REQ-001 Parameter LINES, default 16, number of direct-mapped lines (power of two, 2..256).
REQ-002 Port clk_i  in  1  single clock; all state on rising edge.
REQ-003 Port rst_i  in  1  asynchronous, active-low reset.
REQ-004 Port req_valid_i  in  1  CPU access request.
REQ-005 Port req_write_i  in  1  1 = store word, 0 = load word.
REQ-006 Port req_addr_i  in  32  byte address; bits [1:0] ignored.
REQ-007 Port req_wdata_i  in  32  store data.
REQ-008 Port req_ready_o  out  1  controller can accept a request.
REQ-009 Port resp_valid_o  out  1  one-cycle completion pulse.
REQ-010 Port resp_rdata_o  out  32  load data; 0 for stores.
REQ-011 Port mem_req_o  out  1  backing-memory request, held until acknowledged.
REQ-012 Port mem_write_o  out  1  memory write when 1, read when 0.
REQ-013 Port mem_addr_o  out  32  word-aligned memory byte address.
REQ-014 Port mem_wdata_o  out  32  memory write data.
REQ-015 Port mem_ack_i  in  1  memory completes current request this cycle.
REQ-016 Port mem_rdata_i  in  32  read data, valid when mem_ack_i=1.

Function
REQ-017 Organisation: LINES lines x 4 words; offset = addr[3:2], index = addr[3+log2(LINES):4], tag = remaining upper bits; one valid bit per line.
REQ-018 Policy: write-through, no-write-allocate; cache never holds dirty data.
REQ-019 States: IDLE, HIT, REFILL, WRITE, DONE; request transfer occurs when req_valid_i=1 and req_ready_o=1; req_ready_o=1 only in IDLE.
REQ-020 Address, write flag and wdata are registered at transfer; later changes on req_* are ignored until back in IDLE.
REQ-021 Load hit: IDLE->HIT; resp_valid_o=1 in HIT (cycle after transfer) with the addressed word; HIT->IDLE.
REQ-022 Load miss: IDLE->REFILL; four memory reads, words 0,1,2,3 of the line (mem_addr_o = {line addr, offset, 2'b00}), one outstanding at a time.
REQ-023 In REFILL mem_req_o stays 1 and mem_addr_o stable until mem_ack_i; mem_rdata_i captured into the line on each ack; next word requested the following cycle.
REQ-024 After 4th ack: tag written, valid set, go to DONE; DONE drives resp_valid_o=1 with requested word, then IDLE.
REQ-025 Store: IDLE->WRITE; mem_req_o=1, mem_write_o=1, mem_addr_o/mem_wdata_o = request, held until mem_ack_i.
REQ-026 On store ack: if tag matches a valid line the word is updated in the same edge; then DONE with resp_rdata_o=0; a store miss leaves the cache unchanged.
REQ-027 mem_ack_i while mem_req_o=0 is ignored; mem_write_o=0 outside WRITE.
REQ-028 resp_valid_o is never high for more than one consecutive cycle per request; minimum load-hit throughput one request per 2 cycles.
REQ-029 Ack arriving in the same cycle as mem_req_o first rises is legal (zero-wait memory).
REQ-030 Index collision: a refill overwrites the resident line unconditionally.

Reset
REQ-031 rst_i=0 forces IDLE, clears all valid bits, and drives req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, mem_req_o=0, mem_write_o=0, mem_addr_o=0, mem_wdata_o=0 without waiting for clk_i.
REQ-032 Reset during REFILL or WRITE abandons the transaction; no response issued; the partially filled line remains invalid.
REQ-033 Data and tag arrays need no reset value.

Configuration
REQ-034 With DATA_CACHE_STATS_EN defined, ports hit_cnt_o and miss_cnt_o (out, 32 each) count load hits and load misses, wrap modulo 2^32, clear on reset; stores counted in neither.
REQ-035 Without DATA_CACHE_STATS_EN the ports and counters do not exist and all other behaviour is identical.

Verification
REQ-036 Load 0x0000_0040 after reset, memory acks after 2 wait cycles returning 0xA0,0xA1,0xA2,0xA3 -> four reads 0x40,0x44,0x48,0x4C, resp_rdata_o=0xA0, one resp pulse.
REQ-037 Then load 0x0000_0048 -> resp_valid_o on next cycle with 0xA2, mem_req_o stays 0.
REQ-038 Store 0xDEAD_BEEF to 0x44 (hit) -> memory write 0x44/0xDEADBEEF; later load 0x44 hits returning 0xDEADBEEF.
REQ-039 LINES=16: load 0x140 after 0x40 -> refill evicts; reload 0x40 misses again (stats: hits 2, misses 3 with macro).
REQ-040 Store miss to 0x80 -> single memory write, subsequent load 0x80 misses and refills.
REQ-041 rst_i low after 2nd refill ack -> no resp, mem_req_o=0 immediately; reload of same address refills all 4 words.

Source files
------------

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Optional load hit/miss counters: define DATA_CACHE_STATS_EN.
module data_cache_ctrl #(
    parameter int LINES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        req_ready_o,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        mem_req_o,
    output logic        mem_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
`ifdef DATA_CACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    localparam int IDXW = $clog2(LINES);
    localparam int TAGW = 28 - IDXW;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] HIT    = 3'd1;
    localparam logic [2:0] REFILL = 3'd2;
    localparam logic [2:0] WRITE  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [31:2]     addr_q;
    logic            write_q;
    logic [31:0]     wdata_q;
    logic [1:0]      word_q;
    logic [LINES-1:0] valid_q;

    logic [TAGW-1:0] tag_q  [LINES];
    logic [31:0]     data_q [LINES*4];

    logic [IDXW-1:0] idx_i, idx_q;
    logic [TAGW-1:0] tag_i, tagv_q;
    logic [1:0]      off_q;
    logic            lookup_hit, stored_hit;
    logic            xfer, refill_last, unused_addr;

    assign idx_i  = req_addr_i[4 +: IDXW];
    assign tag_i  = req_addr_i[31 -: TAGW];
    assign idx_q  = addr_q[4 +: IDXW];
    assign tagv_q = addr_q[31 -: TAGW];
    assign off_q  = addr_q[3:2];
    assign unused_addr = ^req_addr_i[1:0];

    assign lookup_hit = valid_q[idx_i] && (tag_q[idx_i] == tag_i);
    assign stored_hit = valid_q[idx_q] && (tag_q[idx_q] == tagv_q);

    assign xfer = req_valid_i && req_ready_o;
    assign refill_last = (state_q == REFILL) && mem_ack_i && (word_q == 2'd3);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (req_write_i)     state_d = WRITE;
                    else if (lookup_hit) state_d = HIT;
                    else                 state_d = REFILL;
                end
            end
            HIT:    state_d = IDLE;
            REFILL: if (refill_last) state_d = DONE;
            WRITE:  if (mem_ack_i) state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            word_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                addr_q  <= req_addr_i[31:2];
                write_q <= req_write_i;
                wdata_q <= req_wdata_i;
                word_q  <= '0;
                // line is invalid while it is being refilled
                if (!req_write_i && !lookup_hit) valid_q[idx_i] <= 1'b0;
            end
            if (state_q == REFILL && mem_ack_i) word_q <= word_q + 2'd1;
            if (refill_last) valid_q[idx_q] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == REFILL && mem_ack_i)
            data_q[{idx_q, word_q}] <= mem_rdata_i;
        if (state_q == WRITE && mem_ack_i && stored_hit)
            data_q[{idx_q, off_q}] <= wdata_q;
        if (refill_last)
            tag_q[idx_q] <= tagv_q;
    end

    always_comb begin
        req_ready_o  = (state_q == IDLE);
        resp_valid_o = (state_q == HIT) || (state_q == DONE);
        resp_rdata_o = '0;
        if (state_q == HIT || (state_q == DONE && !write_q))
            resp_rdata_o = data_q[{idx_q, off_q}];
        mem_req_o   = (state_q == REFILL) || (state_q == WRITE);
        mem_write_o = (state_q == WRITE);
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (state_q == REFILL) mem_addr_o = {addr_q[31:4], word_q, 2'b00};
        if (state_q == WRITE) begin
            mem_addr_o  = {addr_q, 2'b00};
            mem_wdata_o = wdata_q;
        end
    end

`ifdef DATA_CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (xfer && !req_write_i) begin
            if (lookup_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
            else            miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    // no load accounting in this build
`endif

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Randomized bench for data_cache_ctrl against a residency/memory model.
// Model: cached data always equals backing memory (write-through).
module tb_data_cache_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_write_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        req_ready_o, resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        mem_req_o, mem_write_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
`ifdef DATA_CACHE_STATS_EN
    logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

    data_cache_ctrl #(.LINES(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_ready_o(req_ready_o), .resp_valid_o(resp_valid_o),
        .resp_rdata_o(resp_rdata_o),
        .mem_req_o(mem_req_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
`ifdef DATA_CACHE_STATS_EN
        , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] mem [512];
    int  res_line [16];
    bit  res_v [16];
    int  fixed_wait = -1;
    int unsigned hit_m = 0;
    int unsigned miss_m = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int pick_wait();
        return (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) res_v[i] = 1'b0;
        hit_m = 0;
        miss_m = 0;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_ready"}, {31'd0, req_ready_o}, 32'd1);
        check({tag, "_resp"}, {31'd0, resp_valid_o}, 32'd0);
        check({tag, "_rdata"}, resp_rdata_o, 32'd0);
        check({tag, "_mreq"}, {31'd0, mem_req_o}, 32'd0);
        check({tag, "_mwr"}, {31'd0, mem_write_o}, 32'd0);
        check({tag, "_maddr"}, mem_addr_o, 32'd0);
        check({tag, "_mwdata"}, mem_wdata_o, 32'd0);
    endtask

    // abort_n > 0: assert reset right after that many memory acks
    task automatic access(bit wr, logic [31:0] addr, logic [31:0] wd,
                          int abort_n);
        int line, idx, op, nops, waitc;
        bit hit, done, acked;
        logic [31:0] ea, word;
        line = int'(addr >> 4);
        idx  = line % 16;
        hit  = !wr && res_v[idx] && res_line[idx] == line;
        nops = wr ? 1 : (hit ? 0 : 4);
        op = 0;
        done = 0;
        acked = 0;
        @(negedge clk_i);
        check("ready", {31'd0, req_ready_o}, 32'd1);
        check("resp_idle", {31'd0, resp_valid_o}, 32'd0);
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = addr | 32'($urandom_range(0, 3));
        req_wdata_i = wd;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        req_write_i = 1'($urandom);
        req_addr_i  = $urandom;
        req_wdata_i = $urandom;
        waitc = pick_wait();
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            @(negedge clk_i);
            if (acked) begin
                if (wr) mem[addr[10:2]] = wd;
                op++;
                acked = 0;
                mem_ack_i = 1'b0;
                waitc = pick_wait();
                if (abort_n != 0 && op == abort_n) begin
                    rst_i = 1'b0;
                    #1;
                    check_reset_outputs("abort");
                    @(negedge clk_i);
                    check("abort_noresp", {31'd0, resp_valid_o}, 32'd0);
                    rst_i = 1'b1;
                    model_reset();
                    return;
                end
            end
            if (!mem_req_o)
                check("mwr_idle", {31'd0, mem_write_o}, 32'd0);
            if (mem_req_o && op >= nops) begin
                check("mreq_unexp", {31'd0, mem_req_o}, 32'd0);
            end else if (mem_req_o) begin
                word = 32'(op);
                ea = wr ? {addr[31:2], 2'b00} : {addr[31:4], word[1:0], 2'b00};
                check("maddr", mem_addr_o, ea);
                check("mwr", {31'd0, mem_write_o}, {31'd0, wr});
                if (wr) check("mwdata", mem_wdata_o, wd);
                if (waitc == 0) begin
                    mem_ack_i = 1'b1;
                    mem_rdata_i = wr ? $urandom : mem[ea[10:2]];
                    acked = 1;
                end else begin
                    waitc--;
                    mem_ack_i = 1'b0;
                    mem_rdata_i = $urandom;
                end
            end else begin
                mem_ack_i = ($urandom_range(0, 7) == 0);
                mem_rdata_i = $urandom;
            end
            if (resp_valid_o) begin
                check("resp_ops", 32'(op), 32'(nops));
                check("resp_data", resp_rdata_o, wr ? 32'd0 : mem[addr[10:2]]);
                done = 1;
            end
        end
        if (!done) check("timeout", 32'd0, 32'd1);
        mem_ack_i = 1'b0;
        if (!wr) begin
            if (hit) hit_m++;
            else begin
                miss_m++;
                res_v[idx] = 1'b1;
                res_line[idx] = line;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = $urandom;
        model_reset();
        #12;
        check_reset_outputs("rst");
        @(negedge clk_i);
        rst_i = 1'b1;

        fixed_wait = 2;
        mem[16] = 32'hA0;
        mem[17] = 32'hA1;
        mem[18] = 32'hA2;
        mem[19] = 32'hA3;
        access(1'b0, 32'h40, 32'h0, 0);
        access(1'b0, 32'h48, 32'h0, 0);
        access(1'b1, 32'h44, 32'hDEADBEEF, 0);
        access(1'b0, 32'h44, 32'h0, 0);
        check("dir_44", mem[17], 32'hDEADBEEF);
        access(1'b0, 32'h140, 32'h0, 0);
        access(1'b0, 32'h40, 32'h0, 0);
`ifdef DATA_CACHE_STATS_EN
        @(negedge clk_i);
        check("dir_hits", hit_cnt_o, 32'd2);
        check("dir_miss", miss_cnt_o, 32'd3);
`endif
        access(1'b1, 32'h80, 32'h12345678, 0);
        access(1'b0, 32'h80, 32'h0, 0);
        access(1'b0, 32'h200, 32'h0, 2);
`ifdef DATA_CACHE_STATS_EN
        check("rst_hits", hit_cnt_o, 32'd0);
        check("rst_miss", miss_cnt_o, 32'd0);
`endif
        access(1'b0, 32'h200, 32'h0, 0);

        fixed_wait = -1;
        for (int n = 0; n < 300; n++) begin
            bit wr;
            logic [31:0] a;
            wr = ($urandom_range(0, 2) == 0);
            a = {21'd0, 9'($urandom_range(0, 511)), 2'b00};
            access(wr, a, $urandom, 0);
        end
        @(negedge clk_i);
        check("end_resp", {31'd0, resp_valid_o}, 32'd0);
`ifdef DATA_CACHE_STATS_EN
        check("hits", hit_cnt_o, hit_m);
        check("misses", miss_cnt_o, miss_m);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
